// File: rtl/tart_sample_feeder.sv
// tart_sample_feeder
//   Rate-paced antenna-sample source that sits in front of tart_correlator.
//   Samples arrive over a valid/ready handshake and wait in a small FIFO.
//   In RUN, one sample leaves every TRATE clocks as antenna + strobe.
//   Strobes are counted per block, and switch pulses on the last strobe of
//   each block.
//
//   Optional feature (macro TART_FEEDER_STATS_EN):
//     Adds the output port underruns[15:0]. It is a saturating count of
//     empty sample slots, cleared on reset and on IDLE exit.
//
// Ports
//   clk_i      in   1      sole clock
//   rst_i      in   1      asynchronous, active-high reset
//   enable     in   1      run request (level)
//   blocksize  in   BLOCK  samples per block minus one, latched on IDLE exit
//   in_valid   in   1      upstream sample valid
//   in_ready   out  1      FIFO not full (registered)
//   in_data    in   WIDTH  upstream sample
//   strobe     out  1      one-cycle pulse: antenna holds a new sample
//   antenna    out  WIDTH  current sample, held between strobes
//   switch     out  1      one-cycle pulse on the last strobe of a block
//   underflow  out  1      sticky: a sample slot found the FIFO empty
//   busy       out  1      FSM not in IDLE
//   underruns  out  16     empty-slot count (only with TART_FEEDER_STATS_EN)
//
// FSM states
//   state   | meaning
//   S_IDLE  | stopped; FIFO still accepts data
//   S_PRIME | waiting for at least two buffered samples
//   S_RUN   | pacing samples out, one slot every TRATE clocks
module tart_sample_feeder #(
  parameter int WIDTH = 24,
  parameter int TRATE = 12,
  parameter int TBITS = 4,
  parameter int BLOCK = 24,
  parameter int FBITS = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable,
  input  logic [BLOCK-1:0] blocksize,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             strobe,
  output logic [WIDTH-1:0] antenna,
  output logic             switch,
  output logic             underflow,
  output logic             busy
`ifdef TART_FEEDER_STATS_EN
  ,
  output logic [15:0]      underruns
`endif
);

  localparam int DEPTH = 1 << FBITS;
  localparam int CW    = FBITS + 1;
  localparam logic [CW-1:0]    OCC_FULL  = CW'(DEPTH);
  localparam logic [TBITS-1:0] TICK_LAST = TBITS'(TRATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t           r_state;
  logic [TBITS-1:0] r_tick;
  logic [BLOCK-1:0] r_scnt;
  logic [BLOCK-1:0] r_bs;
  logic             r_strobe;
  logic [WIDTH-1:0] r_antenna;
  logic             r_switch;
  logic             r_underflow;
  logic             r_busy;
  logic             r_in_ready;
`ifdef TART_FEEDER_STATS_EN
  logic [15:0]      r_underruns;
`endif

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [FBITS-1:0] r_wptr;
  logic [FBITS-1:0] r_rptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_slot;
  logic             w_pop;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] w_head;

  // in_ready is registered as !full, so a push can never land on a full FIFO.
  // A slot is only honoured while enable is still high; dropping enable
  // pre-empts it.
  assign w_push       = in_valid && r_in_ready;
  assign w_slot       = (r_state == S_RUN) && enable && (r_tick == TICK_LAST);
  assign w_pop        = w_slot && (r_count != '0);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_head       = r_mem[r_rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != OCC_FULL);
      if (w_push) r_wptr <= r_wptr + FBITS'(1);
      if (w_pop)  r_rptr <= r_rptr + FBITS'(1);
    end
  end

  // Storage needs no reset: the pointers and the count define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_scnt      <= '0;
      r_bs        <= '0;
      r_strobe    <= 1'b0;
      r_antenna   <= '0;
      r_switch    <= 1'b0;
      r_underflow <= 1'b0;
      r_busy      <= 1'b0;
`ifdef TART_FEEDER_STATS_EN
      r_underruns <= '0;
`endif
    end else begin
      r_strobe <= 1'b0;
      r_switch <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state     <= S_PRIME;
            r_bs        <= blocksize;
            r_underflow <= 1'b0;
            r_tick      <= '0;
            r_scnt      <= '0;
            r_busy      <= 1'b1;
`ifdef TART_FEEDER_STATS_EN
            r_underruns <= '0;
`endif
          end
        end
        S_PRIME: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_tick  <= '0;
            r_scnt  <= '0;
          end else if ((r_count >= CW'(2)) || (r_count == OCC_FULL)) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_tick  <= '0;
            r_scnt  <= '0;
          end else begin
            r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + TBITS'(1);
            if (w_slot) begin
              if (w_pop) begin
                r_antenna <= w_head;
                r_strobe  <= 1'b1;
                if (r_scnt == r_bs) begin
                  r_scnt   <= '0;
                  r_switch <= 1'b1;
                end else begin
                  r_scnt <= r_scnt + BLOCK'(1);
                end
              end else begin
                // Empty slot: nothing is emitted, so the block count stays put.
                r_underflow <= 1'b1;
`ifdef TART_FEEDER_STATS_EN
                if (r_underruns != 16'hFFFF) r_underruns <= r_underruns + 16'd1;
`endif
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign strobe    = r_strobe;
  assign antenna   = r_antenna;
  assign switch    = r_switch;
  assign underflow = r_underflow;
  assign busy      = r_busy;
`ifdef TART_FEEDER_STATS_EN
  assign underruns = r_underruns;
`endif

endmodule

// File: tb/tb_tart_sample_feeder.sv
module tb_tart_sample_feeder;
  localparam int WIDTH = 24;
  localparam int TRATE = 12;
  localparam int TBITS = 4;
  localparam int BLOCK = 24;
  localparam int FBITS = 2;
  localparam int DEPTH = 4;

  logic             clk_i;
  logic             rst_i;
  logic             enable;
  logic [BLOCK-1:0] blocksize;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             strobe;
  logic [WIDTH-1:0] antenna;
  logic             switch;
  logic             underflow;
  logic             busy;
`ifdef TART_FEEDER_STATS_EN
  logic [15:0]      underruns;
`endif

  tart_sample_feeder #(
    .WIDTH(WIDTH), .TRATE(TRATE), .TBITS(TBITS), .BLOCK(BLOCK), .FBITS(FBITS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable(enable), .blocksize(blocksize),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .strobe(strobe), .antenna(antenna), .switch(switch),
    .underflow(underflow), .busy(busy)
`ifdef TART_FEEDER_STATS_EN
    , .underruns(underruns)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    blocksize = '0;
    in_data   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Steps n cycles; the strobe must appear on exactly the n-th one.
  task automatic expect_strobe_in(input int n, input logic [WIDTH-1:0] ant,
                                  input logic sw, input string name);
    bit early;
    early = 1'b0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (i < n && (strobe || switch)) early = 1'b1;
    end
    check({name, " early"}, 64'(early), 64'd0);
    check({name, " strobe"}, 64'(strobe), 64'd1);
    check({name, " antenna"}, 64'(antenna), 64'(ant));
    check({name, " switch"}, 64'(sw ? switch : switch), 64'(sw));
  endtask

  task automatic expect_empty_slot(input int n, input logic [WIDTH-1:0] held, input string name);
    bit early;
    early = 1'b0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (i < n && (strobe || switch || underflow)) early = 1'b1;
    end
    check({name, " early"}, 64'(early), 64'd0);
    check({name, " strobe"}, 64'(strobe), 64'd0);
    check({name, " underflow"}, 64'(underflow), 64'd1);
    check({name, " antenna"}, 64'(antenna), 64'(held));
  endtask

  // Reference model: a queue plus a mode number and a slot phase.
  int               m_mode;   // 0 stopped, 1 priming, 2 running
  logic [WIDTH-1:0] m_q[$];
  int               m_phase, m_cnt, m_runs;
  logic [BLOCK-1:0] m_bs;
  logic             m_strobe, m_switch, m_uf, m_busy, m_ready;
  logic [WIDTH-1:0] m_ant;

  function automatic void model_reset();
    m_q.delete();
    m_mode = 0; m_phase = 0; m_cnt = 0; m_runs = 0; m_bs = '0;
    m_strobe = 0; m_switch = 0; m_uf = 0; m_busy = 0; m_ready = 1; m_ant = '0;
  endfunction

  function automatic void model_step();
    bit push;
    push = in_valid && m_ready;
    m_strobe = 0;
    m_switch = 0;
    if (m_mode == 0) begin
      if (enable) begin
        m_mode = 1; m_bs = blocksize; m_uf = 0; m_phase = 0; m_cnt = 0; m_runs = 0;
      end
    end else if (!enable) begin
      m_mode = 0; m_phase = 0; m_cnt = 0;
    end else if (m_mode == 1) begin
      if (m_q.size() >= 2) m_mode = 2;
    end else begin
      if (m_phase == TRATE - 1) begin
        if (m_q.size() > 0) begin
          m_ant = m_q.pop_front();
          m_strobe = 1;
          if (m_cnt == int'(m_bs)) begin m_switch = 1; m_cnt = 0; end
          else m_cnt++;
        end else begin
          m_uf = 1;
          if (m_runs < 65535) m_runs++;
        end
      end
      m_phase = (m_phase + 1) % TRATE;
    end
    if (push) m_q.push_back(in_data);
    m_ready = (m_q.size() < DEPTH);
    m_busy  = (m_mode != 0);
  endfunction

  function automatic logic [63:0] dut_pack();
`ifdef TART_FEEDER_STATS_EN
    return 64'({underruns, in_ready, strobe, switch, underflow, busy, antenna});
`else
    return 64'({in_ready, strobe, switch, underflow, busy, antenna});
`endif
  endfunction

  function automatic logic [63:0] model_pack();
`ifdef TART_FEEDER_STATS_EN
    return 64'({16'(m_runs), m_ready, m_strobe, m_switch, m_uf, m_busy, m_ant});
`else
    return 64'({m_ready, m_strobe, m_switch, m_uf, m_busy, m_ant});
`endif
  endfunction

  typedef struct {
    logic             en;
    logic [BLOCK-1:0] bsz;
    logic             vld;
    logic [WIDTH-1:0] d;
    logic             e_ready;
    logic             e_busy;
  } vec_t;

  vec_t tbl[8];

  localparam logic [WIDTH-1:0] A1 = 24'hA00001, A2 = 24'hA00002, A3 = 24'hA00003,
                               A4 = 24'hA00004, A5 = 24'hA00005;
  localparam logic [WIDTH-1:0] B1 = 24'hB00001, B2 = 24'hB00002, B3 = 24'hB00003;

  logic [WIDTH-1:0] words[64];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{en:1'b0, bsz:24'd0, vld:1'b1, d:A1, e_ready:1'b1, e_busy:1'b0};
    tbl[1] = '{en:1'b0, bsz:24'd0, vld:1'b1, d:A2, e_ready:1'b1, e_busy:1'b0};
    tbl[2] = '{en:1'b0, bsz:24'd0, vld:1'b1, d:A3, e_ready:1'b1, e_busy:1'b0};
    tbl[3] = '{en:1'b0, bsz:24'd0, vld:1'b1, d:A4, e_ready:1'b0, e_busy:1'b0};
    tbl[4] = '{en:1'b0, bsz:24'd0, vld:1'b1, d:A5, e_ready:1'b0, e_busy:1'b0};
    tbl[5] = '{en:1'b1, bsz:24'd0, vld:1'b0, d:24'd0, e_ready:1'b0, e_busy:1'b1};
    tbl[6] = '{en:1'b1, bsz:24'd0, vld:1'b0, d:24'd0, e_ready:1'b0, e_busy:1'b1};
    tbl[7] = '{en:1'b0, bsz:24'd0, vld:1'b0, d:24'd0, e_ready:1'b0, e_busy:1'b0};

    rst_i = 1'b1;
    do_reset();
    check("reset state", 64'({in_ready, strobe, switch, underflow, busy, antenna}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0}));

    // Fill to full (fifth word refused), then a short enable pulse.
    for (int i = 0; i < 8; i++) begin
      enable    = tbl[i].en;
      blocksize = tbl[i].bsz;
      in_valid  = tbl[i].vld;
      in_data   = tbl[i].d;
      step();
      check($sformatf("vec%0d", i), 64'({in_ready, busy, strobe, underflow}),
            64'({tbl[i].e_ready, tbl[i].e_busy, 2'b00}));
    end
    in_valid = 1'b0;

    // Paced output, block of 4, then starvation.
    enable = 1'b1; blocksize = 24'd3;
    step();
    check("prime busy", 64'({busy, underflow}), 64'({1'b1, 1'b0}));
    step();
    expect_strobe_in(TRATE, A1, 1'b0, "t1 s1");
    expect_strobe_in(TRATE, A2, 1'b0, "t1 s2");
    expect_strobe_in(TRATE, A3, 1'b0, "t1 s3");
    expect_strobe_in(TRATE, A4, 1'b1, "t1 s4");
    expect_empty_slot(TRATE, A4, "t3 empty");
    repeat (TRATE) step();
    check("t3 sticky", 64'(underflow), 64'd1);
    enable = 1'b0;
    step();
    check("t3 idle", 64'({busy, underflow}), 64'({1'b0, 1'b1}));

    // Mid-block stop, restart with blocksize 1.
    in_valid = 1'b1;
    in_data = B1; step();
    in_data = B2; step();
    in_data = B3; step();
    in_valid = 1'b0;
    enable = 1'b1; blocksize = 24'd3;
    step();
    check("t3 reenable clears", 64'({busy, underflow}), 64'({1'b1, 1'b0}));
    step();
    expect_strobe_in(TRATE, B1, 1'b0, "t5 b1");
    enable = 1'b0;
    step();
    check("t5 stop", 64'(busy), 64'd0);
    enable = 1'b1; blocksize = 24'd1;
    step();
    step();
    expect_strobe_in(TRATE, B2, 1'b0, "t5 b2");
    expect_strobe_in(TRATE, B3, 1'b1, "t5 b3");

    // Held valid, slow drain: every word emitted once, in order.
    begin
      int  idx, got;
      bit  acc, saw_full;
      for (int i = 0; i < 64; i++) words[i] = WIDTH'($urandom);
      do_reset();
      enable = 1'b1; blocksize = '0;
      in_valid = 1'b1; in_data = words[0];
      idx = 0; got = 0; saw_full = 0;
      for (int c = 0; c < 64 * TRATE + 200 && got < 64; c++) begin
        acc = in_valid && in_ready;
        step();
        if (acc) begin
          idx++;
          if (idx < 64) in_data = words[idx];
          else in_valid = 1'b0;
        end
        if (!in_ready) saw_full = 1;
        if (strobe) begin
          check($sformatf("t4 word%0d", got), 64'(antenna), 64'(words[got]));
          got++;
        end
      end
      check("t4 all words out", 64'(got), 64'd64);
      check("t4 ready dropped", 64'(saw_full), 64'd1);
      check("t4 no underflow", 64'(underflow), 64'd0);
    end

    // Random traffic against the reference model.
    begin
      int dens;
      int errs;
      do_reset();
      model_reset();
      enable = 1'b1;
      dens = 50;
      errs = 0;
      for (int c = 0; c < 3000; c++) begin
        if (c % 400 == 0) dens = $urandom_range(0, 4) * 25;
        if ($urandom_range(0, 299) == 0) enable = ~enable;
        blocksize = BLOCK'($urandom_range(0, 4));
        in_valid  = ($urandom_range(0, 99) < dens);
        in_data   = WIDTH'($urandom);
        model_step();
        step();
        if (dut_pack() !== model_pack() && errs < 20) begin
          errs++;
          check($sformatf("rand cyc%0d", c), dut_pack(), model_pack());
        end else if (dut_pack() === model_pack() && c % 10 == 0) begin
          check($sformatf("rand cyc%0d", c), dut_pack(), model_pack());
        end
      end
    end

    // Asynchronous reset in the middle of RUN.
    do_reset();
    in_valid = 1'b1;
    in_data = 24'h5A0001; step();
    in_data = 24'h5A0002; step();
    in_data = 24'h5A0003; step();
    in_valid = 1'b0;
    enable = 1'b1; blocksize = '0;
    repeat (60) step();
    check("t6 pre busy/underflow/antenna", 64'({busy, underflow, antenna}),
          64'({1'b1, 1'b1, 24'h5A0003}));
`ifdef TART_FEEDER_STATS_EN
    check("t6 pre underruns", 64'(underruns), 64'd1);
`endif
    #2 rst_i = 1'b1;
    #1;
    check("t6 async reset", 64'({in_ready, strobe, switch, underflow, busy, antenna}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0}));
`ifdef TART_FEEDER_STATS_EN
    check("t6 underruns", 64'(underruns), 64'd0);
`endif
    enable = 1'b0;
    step();
    rst_i = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
